mips_controller: RTL and testbench

//  Main control unit of the single-cycle MIPS datapath. Decodes opcode/funct
//  (plus ALU zero flag) into datapath controls: mux selects, write enables,

---
 rtl/mips_controller.sv | 176 +++++++++++++++++
 tb/tb_mips_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_controller.sv
// Main control unit for the single-cycle MIPS datapath.
// Ports:
//   clk, reset (async, active-low)
//   op, funct  : instruction opcode and R-type function field
//   zero       : ALU result-is-zero flag, used only by beq
//   memtoreg, memwrite, pcsrc, alusrc, regdst, regwrite, jump : datapath controls
//   alucontrol : 3-bit ALU operation
//   illegal    : sticky flag, set once an unsupported op/funct is clocked in
module mips_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memtoreg,
    output logic       memwrite,
    output logic       pcsrc,
    output logic       alusrc,
    output logic       regdst,
    output logic       regwrite,
    output logic       jump,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10
    } aluop_e;

    logic is_r;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_addi;
    logic is_j;

    assign is_r    = (op == OP_RTYPE);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_addi = (op == OP_ADDI);
    assign is_j    = (op == OP_J);

    logic   regwrite_dec;
    logic   regdst_dec;
    logic   alusrc_dec;
    logic   branch_dec;
    logic   memwrite_dec;
    logic   memtoreg_dec;
    logic   jump_dec;
    aluop_e aluop;
    logic   op_legal;

    // Opcode compares are mutually exclusive, so a parallel decoder is safe.
    always_comb begin
        regwrite_dec = 1'b0;
        regdst_dec   = 1'b0;
        alusrc_dec   = 1'b0;
        branch_dec   = 1'b0;
        memwrite_dec = 1'b0;
        memtoreg_dec = 1'b0;
        jump_dec     = 1'b0;
        aluop        = AOP_ADD;
        op_legal     = 1'b1;
        unique case (1'b1)
            is_r: begin
                regwrite_dec = 1'b1;
                regdst_dec   = 1'b1;
                aluop        = AOP_FUNCT;
            end
            is_lw: begin
                regwrite_dec = 1'b1;
                alusrc_dec   = 1'b1;
                memtoreg_dec = 1'b1;
            end
            is_sw: begin
                alusrc_dec   = 1'b1;
                memwrite_dec = 1'b1;
            end
            is_beq: begin
                branch_dec   = 1'b1;
                aluop        = AOP_SUB;
            end
            is_addi: begin
                regwrite_dec = 1'b1;
                alusrc_dec   = 1'b1;
            end
            is_j: begin
                jump_dec     = 1'b1;
            end
            default: begin
                op_legal     = 1'b0;
            end
        endcase
    end

    logic [2:0] alucontrol_dec;
    logic       funct_legal;

    always_comb begin
        alucontrol_dec = ALU_ADD;
        funct_legal    = 1'b1;
        case (aluop)
            AOP_ADD: alucontrol_dec = ALU_ADD;
            AOP_SUB: alucontrol_dec = ALU_SUB;
            AOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol_dec = ALU_ADD;
                    FN_SUB:  alucontrol_dec = ALU_SUB;
                    FN_AND:  alucontrol_dec = ALU_AND;
                    FN_OR:   alucontrol_dec = ALU_OR;
                    FN_SLT:  alucontrol_dec = ALU_SLT;
                    default: begin
                        alucontrol_dec = ALU_ADD;
                        funct_legal    = 1'b0;
                    end
                endcase
            end
            default: alucontrol_dec = ALU_ADD;
        endcase
    end

    // funct_legal is only ever cleared for R-type, so no op qualifier needed.
    logic illegal_now;
    assign illegal_now = ~op_legal | ~funct_legal;

    // State-changing enables are gated by reset so nothing architectural
    // moves while the core is held in reset.
    assign regwrite   = regwrite_dec & reset;
    assign memwrite   = memwrite_dec & reset;
    assign pcsrc      = branch_dec & zero & reset;
    assign jump       = jump_dec & reset;
    assign regdst     = regdst_dec;
    assign alusrc     = alusrc_dec;
    assign memtoreg   = memtoreg_dec;
    assign alucontrol = alucontrol_dec;

    logic illegal_q;
    logic illegal_d;

    always_comb begin
        illegal_d = illegal_q | illegal_now;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_controller.sv
// Randomized bench for mips_controller against a table-driven model.
// Compares the full control word and the sticky illegal flag every cycle.
module tb_mips_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memtoreg;
    logic       memwrite;
    logic       pcsrc;
    logic       alusrc;
    logic       regdst;
    logic       regwrite;
    logic       jump;
    logic [2:0] alucontrol;
    logic       illegal;

    int n_tests;
    int n_fail;
    logic model_ill;

    mips_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memtoreg   (memtoreg),
        .memwrite   (memwrite),
        .pcsrc      (pcsrc),
        .alusrc     (alusrc),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .jump       (jump),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [15:0] got,
                         input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Spec table: {regwrite,regdst,alusrc,branch,memwrite,memtoreg,jump}
    function automatic logic [6:0] main_row(input logic [5:0] o);
        case (o)
            6'b000000: return 7'b1100000;
            6'b100011: return 7'b1010010;
            6'b101011: return 7'b0010100;
            6'b000100: return 7'b0001000;
            6'b001000: return 7'b1010000;
            6'b000010: return 7'b0000001;
            default:   return 7'b0000000;
        endcase
    endfunction

    function automatic bit op_known(input logic [5:0] o);
        return o inside {6'b000000, 6'b100011, 6'b101011,
                         6'b000100, 6'b001000, 6'b000010};
    endfunction

    function automatic bit funct_known(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100,
                         6'b100101, 6'b101010};
    endfunction

    function automatic bit model_illegal(input logic [5:0] o,
                                         input logic [5:0] f);
        if (!op_known(o)) return 1'b1;
        if (o == 6'b000000 && !funct_known(f)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] model_alu(input logic [5:0] o,
                                             input logic [5:0] f);
        if (o == 6'b000100) return 3'b110;
        if (o != 6'b000000) return 3'b010;
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Packed: {regwrite,regdst,alusrc,pcsrc,memwrite,memtoreg,jump,alu[2:0]}
    function automatic logic [9:0] model_ctl(input logic [5:0] o,
                                             input logic [5:0] f,
                                             input logic z,
                                             input logic r);
        logic [6:0] m;
        logic rw, rd, as, br, mw, mr, jp;
        m = main_row(o);
        {rw, rd, as, br, mw, mr, jp} = m;
        return {rw & r, rd, as, br & z & r, mw & r, mr, jp & r,
                model_alu(o, f)};
    endfunction

    function automatic logic [9:0] dut_ctl();
        return {regwrite, regdst, alusrc, pcsrc, memwrite, memtoreg,
                jump, alucontrol};
    endfunction

    // One cycle: drive on negedge, check combinational outputs, then the
    // sticky flag after the following posedge.
    task automatic step(input string tag,
                        input logic [5:0] o,
                        input logic [5:0] f,
                        input logic z,
                        input logic r);
        @(negedge clk);
        op = o;
        funct = f;
        zero = z;
        reset = r;
        #1;
        if (!r) model_ill = 1'b0;
        check({tag, ".ctl"}, {6'd0, dut_ctl()},
              {6'd0, model_ctl(o, f, z, r)});
        check({tag, ".ill"}, {15'd0, illegal}, {15'd0, model_ill});
        @(posedge clk);
        #1;
        if (r && model_illegal(o, f)) model_ill = 1'b1;
        check({tag, ".ill_edge"}, {15'd0, illegal}, {15'd0, model_ill});
    endtask

    logic [5:0] legal_ops [6];
    logic [5:0] legal_fn [5];

    initial begin
        n_tests = 0;
        n_fail = 0;
        model_ill = 1'b0;
        legal_ops = '{6'b000000, 6'b100011, 6'b101011,
                      6'b000100, 6'b001000, 6'b000010};
        legal_fn = '{6'b100000, 6'b100010, 6'b100100,
                     6'b100101, 6'b101010};
        reset = 1'b0;
        op = 6'b100011;
        funct = 6'd0;
        zero = 1'b0;
        #2;
        check("reset.ill", {15'd0, illegal}, 16'd0);
        check("reset.regwrite", {15'd0, regwrite}, 16'd0);
        check("reset.ctl", {6'd0, dut_ctl()}, {6'd0, 10'b0010010010});

        step("rst_hold", 6'b111111, 6'd0, 1'b1, 1'b0);
        step("r_add", 6'b000000, 6'b100000, 1'b0, 1'b1);
        check("r_add.direct", {6'd0, dut_ctl()}, {6'd0, 10'b1100000010});
        step("r_slt", 6'b000000, 6'b101010, 1'b0, 1'b1);
        check("r_slt.alu", {13'd0, alucontrol}, 16'h0007);
        step("lw", 6'b100011, 6'd0, 1'b1, 1'b1);
        step("sw", 6'b101011, 6'd0, 1'b0, 1'b1);
        check("sw.memwrite", {15'd0, memwrite}, 16'd1);
        step("beq_t", 6'b000100, 6'd0, 1'b1, 1'b1);
        check("beq_t.pcsrc", {15'd0, pcsrc}, 16'd1);
        step("beq_nt", 6'b000100, 6'd0, 1'b0, 1'b1);
        step("j", 6'b000010, 6'd0, 1'b1, 1'b1);
        check("j.direct", {6'd0, dut_ctl()}, {6'd0, 10'b0000001010});
        step("addi", 6'b001000, 6'd0, 1'b1, 1'b1);
        step("bad_op", 6'b111111, 6'd0, 1'b1, 1'b1);
        check("bad_op.ill", {15'd0, illegal}, 16'd1);
        step("legal_after", 6'b100011, 6'd0, 1'b0, 1'b1);
        check("sticky.ill", {15'd0, illegal}, 16'd1);

        // Mid-cycle reset pulse clears the flag without a clock edge.
        @(negedge clk);
        #2;
        op = 6'b100011;
        reset = 1'b0;
        #1;
        model_ill = 1'b0;
        check("pulse.ill", {15'd0, illegal}, 16'd0);
        check("pulse.we", {14'd0, regwrite, memwrite}, 16'd0);
        reset = 1'b1;

        step("bad_funct", 6'b000000, 6'b000000, 1'b0, 1'b1);
        check("bad_funct.ill", {15'd0, illegal}, 16'd1);
        step("rst_clr", 6'b000000, 6'b100000, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [5:0] o;
            logic [5:0] f;
            logic z;
            logic r;
            o = ($urandom_range(0, 4) == 0) ? 6'($urandom)
                : legal_ops[$urandom_range(0, 5)];
            f = ($urandom_range(0, 5) == 0) ? 6'($urandom)
                : legal_fn[$urandom_range(0, 4)];
            z = 1'($urandom);
            r = ($urandom_range(0, 15) != 0);
            step("rand", o, f, z, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
